// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads instruction memory over a req/ack
// handshake and queues returned words with their PC+4 for the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stalld,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] rd,
    output logic [31:0] pcp4f,
    output logic        fetch_empty,
    output logic [31:0] pcf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              req_reg, req_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       pcf_reg, pcf_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;

    logic [31:0]       instr_mem [DEPTH];
    logic [31:0]       pcp4_mem  [DEPTH];

    logic              push, pop, space, head_valid;
    logic [31:0]       target_aligned, addr_plus4, pcf_plus4;

    assign target_aligned = pc_target & 32'hFFFF_FFFC;
    assign addr_plus4     = addr_reg + 32'd4;
    assign pcf_plus4      = pcf_reg + 32'd4;

    // A word returning together with a redirect is never enqueued.
    assign push = (state_reg == BUSY) && imem_ack && !pc_src;
    assign pop  = (count_reg != '0) && !stalld && !pc_src;

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (pc_src) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // A new request is only launched if its word is guaranteed a slot.
    assign space = (count_next < DEPTH_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!pc_src && space) state_next = BUSY;
            end
            BUSY: begin
                if (imem_ack) begin
                    if (pc_src || !space) state_next = IDLE;
                end else if (pc_src) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_next  = req_reg;
        addr_next = addr_reg;
        pcf_next  = pcf_reg;
        case (state_reg)
            IDLE: begin
                if (pc_src) begin
                    pcf_next = target_aligned;
                end else if (space) begin
                    addr_next = pcf_reg;
                    req_next  = 1'b1;
                end
            end
            BUSY: begin
                if (imem_ack && !pc_src) begin
                    pcf_next = pcf_plus4;
                    if (space) begin
                        addr_next = pcf_plus4;
                    end else begin
                        req_next = 1'b0;
                    end
                end else if (imem_ack) begin
                    pcf_next = target_aligned;
                    req_next = 1'b0;
                end else if (pc_src) begin
                    // Keep the old request on the bus until memory answers it.
                    pcf_next = target_aligned;
                end
            end
            DROP: begin
                if (pc_src)   pcf_next = target_aligned;
                if (imem_ack) req_next = 1'b0;
            end
            default: req_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_reg    <= 1'b0;
            addr_reg   <= 32'h0000_0000;
            pcf_reg    <= RESET_PC_ALIGNED;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            req_reg    <= req_next;
            addr_reg   <= addr_next;
            pcf_reg    <= pcf_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Queue storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pcp4_mem[wr_ptr_reg]  <= addr_plus4;
        end
    end

    assign head_valid  = (count_reg != '0) && !pc_src;
    assign rd          = head_valid ? instr_mem[rd_ptr_reg] : 32'h0000_0000;
    assign pcp4f       = head_valid ? pcp4_mem[rd_ptr_reg]  : 32'h0000_0000;
    assign fetch_empty = (count_reg == '0);
    assign imem_req    = req_reg;
    assign imem_addr   = addr_reg;
    assign pcf         = pcf_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table against a simple
// memory model whose read data is the address XOR 32'hA5A5_0000.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stalld;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] rd;
    logic [31:0] pcp4f;
    logic        fetch_empty;
    logic [31:0] pcf;

    // ack_mode: 0 = model with wait_n wait states, 1 = forced low, 2 = forced high
    logic [1:0]  ack_mode;
    int          wait_n;
    int          cnt;
    int          checks;
    int          errors;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stalld      (stalld),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .rd          (rd),
        .pcp4f       (pcp4f),
        .fetch_empty (fetch_empty),
        .pcf         (pcf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_ack = 1'b0;
        case (ack_mode)
            2'd1:    imem_ack = 1'b0;
            2'd2:    imem_ack = 1'b1;
            default: imem_ack = imem_req && (cnt >= wait_n);
        endcase
    end

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) cnt <= cnt + 1;
        else                       cnt <= 0;
    end

    typedef struct {
        logic        rst_n;
        logic        stalld;
        logic        pc_src;
        logic [31:0] target;
        logic [1:0]  mode;
        int          wait_n;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        logic [31:0] exp_pcp4f;
        logic        exp_empty;
        logic [31:0] exp_pcf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic st, input logic ps, input logic [31:0] tg,
                       input logic [1:0] m, input int w, input logic e_req,
                       input logic [31:0] e_addr, input logic [31:0] e_rd,
                       input logic [31:0] e_p, input logic e_empty, input logic [31:0] e_pcf);
        vec_t v;
        v.rst_n = r;        v.stalld = st;      v.pc_src = ps;      v.target = tg;
        v.mode = m;         v.wait_n = w;       v.exp_req = e_req;  v.exp_addr = e_addr;
        v.exp_rd = e_rd;    v.exp_pcp4f = e_p;  v.exp_empty = e_empty; v.exp_pcf = e_pcf;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        cnt       = 0;
        rst_n     = 1'b0;
        stalld    = 1'b0;
        pc_src    = 1'b0;
        pc_target = 32'h0;
        ack_mode  = 2'd0;
        wait_n    = 0;

        // Zero-wait stream, then a 6-cycle decode stall
        add(1,0,0,0,0,0, 0,32'h000,32'h0,        32'h000,1,32'h000);
        add(1,0,0,0,0,0, 1,32'h000,32'h0,        32'h000,1,32'h000);
        add(1,0,0,0,0,0, 1,32'h004,32'hA5A50000, 32'h004,0,32'h004);
        add(1,0,0,0,0,0, 1,32'h008,32'hA5A50004, 32'h008,0,32'h008);
        add(1,1,0,0,0,0, 1,32'h00C,32'hA5A50008, 32'h00C,0,32'h00C);
        for (int i = 0; i < 5; i++)
            add(1,1,0,0,0,0, 0,32'h00C,32'hA5A50008, 32'h00C,0,32'h010);
        add(1,0,0,0,0,0, 0,32'h00C,32'hA5A50008, 32'h00C,0,32'h010);
        add(1,0,0,0,0,0, 1,32'h010,32'hA5A5000C, 32'h010,0,32'h010);
        add(1,0,0,0,0,0, 1,32'h014,32'hA5A50010, 32'h014,0,32'h014);
        // Reset, then 2-wait-state memory
        add(0,0,0,0,0,2, 0,32'h000,32'h0,        32'h000,1,32'h000);
        add(1,0,0,0,0,2, 0,32'h000,32'h0,        32'h000,1,32'h000);
        for (int i = 0; i < 3; i++)
            add(1,0,0,0,0,2, 1,32'h000,32'h0,    32'h000,1,32'h000);
        add(1,0,0,0,0,2, 1,32'h004,32'hA5A50000, 32'h004,0,32'h004);
        add(1,0,0,0,0,2, 1,32'h004,32'h0,        32'h000,1,32'h004);
        add(1,0,0,0,0,2, 1,32'h004,32'h0,        32'h000,1,32'h004);
        add(1,0,0,0,0,2, 1,32'h008,32'hA5A50004, 32'h008,0,32'h008);
        add(1,0,0,0,0,2, 1,32'h008,32'h0,        32'h000,1,32'h008);
        // Redirect while BUSY with ack low: DROP, late ack discarded
        add(1,0,1,32'h103,1,2, 1,32'h008,32'h0,  32'h000,1,32'h008);
        add(1,0,0,0,1,2, 1,32'h008,32'h0,        32'h000,1,32'h100);
        add(1,0,0,0,2,2, 1,32'h008,32'h0,        32'h000,1,32'h100);
        add(1,0,0,0,0,0, 0,32'h008,32'h0,        32'h000,1,32'h100);
        add(1,0,0,0,0,0, 1,32'h100,32'h0,        32'h000,1,32'h100);
        add(1,0,0,0,0,0, 1,32'h104,32'hA5A50100, 32'h104,0,32'h104);
        // Redirect together with ack under stall: word dropped, queue flushed
        add(1,1,1,32'h200,0,0, 1,32'h108,32'h0,  32'h000,0,32'h108);
        add(1,1,0,0,0,0, 0,32'h108,32'h0,        32'h000,1,32'h200);
        add(1,1,0,0,0,0, 1,32'h200,32'h0,        32'h000,1,32'h200);
        add(1,1,0,0,0,0, 1,32'h204,32'hA5A50200, 32'h204,0,32'h204);
        add(1,1,0,0,0,0, 0,32'h204,32'hA5A50200, 32'h204,0,32'h208);
        // Redirect with the queue full; ack forced high in IDLE is ignored
        add(1,1,1,32'h300,2,0, 0,32'h204,32'h0,  32'h000,0,32'h208);
        add(1,0,0,0,2,0, 0,32'h204,32'h0,        32'h000,1,32'h300);
        add(1,0,0,0,0,0, 1,32'h300,32'h0,        32'h000,1,32'h300);
        add(1,0,0,0,0,0, 1,32'h304,32'hA5A50300, 32'h304,0,32'h304);
        // Reset pulse mid-BUSY, stray ack after release
        add(1,0,0,0,1,0, 1,32'h308,32'hA5A50304, 32'h308,0,32'h308);
        add(1,0,0,0,1,0, 1,32'h308,32'h0,        32'h000,1,32'h308);
        add(0,0,0,0,1,0, 0,32'h000,32'h0,        32'h000,1,32'h000);
        add(1,0,0,0,2,0, 0,32'h000,32'h0,        32'h000,1,32'h000);
        add(1,0,0,0,2,0, 1,32'h000,32'h0,        32'h000,1,32'h000);
        add(1,0,0,0,0,0, 1,32'h004,32'hA5A50000, 32'h004,0,32'h004);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req",   -1, {31'b0, imem_req},    32'h0);
        chk("reset_addr",  -1, imem_addr,            32'h0);
        chk("reset_pcf",   -1, pcf,                  32'h0);
        chk("reset_empty", -1, {31'b0, fetch_empty}, 32'h1);
        chk("reset_rd",    -1, rd,                   32'h0);
        chk("reset_pcp4f", -1, pcp4f,                32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            rst_n     = vq[i].rst_n;
            stalld    = vq[i].stalld;
            pc_src    = vq[i].pc_src;
            pc_target = vq[i].target;
            ack_mode  = vq[i].mode;
            wait_n    = vq[i].wait_n;
            #1;
            $display("step %0d: req=%0b addr=%h ack=%0b rd=%h pcp4f=%h empty=%0b pcf=%h",
                     i, imem_req, imem_addr, imem_ack, rd, pcp4f, fetch_empty, pcf);
            chk("imem_req",    i, {31'b0, imem_req},    {31'b0, vq[i].exp_req});
            chk("imem_addr",   i, imem_addr,            vq[i].exp_addr);
            chk("rd",          i, rd,                   vq[i].exp_rd);
            chk("pcp4f",       i, pcp4f,                vq[i].exp_pcp4f);
            chk("fetch_empty", i, {31'b0, fetch_empty}, {31'b0, vq[i].exp_empty});
            chk("pcf",         i, pcf,                  vq[i].exp_pcf);
        end

        // Redirect to the top of the address space; PC+4 must wrap to 0
        @(negedge clk);
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFF;
        #1;
        $display("wrap redirect: rd=%h empty=%0b", rd, fetch_empty);
        chk("redirect_bubble_rd", 100, rd, 32'h0);
        chk("redirect_nonempty",  100, {31'b0, fetch_empty}, 32'h0);
        @(negedge clk);
        pc_src = 1'b0;
        #1;
        n = 0;
        while (!(imem_req && imem_addr == 32'hFFFF_FFFC) && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        $display("wrap request: req=%0b addr=%h after %0d cycles", imem_req, imem_addr, n);
        chk("wrap_req_issued", 101, {31'b0, imem_req && imem_addr == 32'hFFFF_FFFC}, 32'h1);
        chk("wrap_latency",    101, n, 32'd1);
        chk("wrap_pcf",        101, pcf, 32'hFFFF_FFFC);
        @(negedge clk);
        #1;
        $display("wrap word: rd=%h pcp4f=%h addr=%h pcf=%h", rd, pcp4f, imem_addr, pcf);
        chk("wrap_rd",    102, rd,        32'h5A5A_FFFC);
        chk("wrap_pcp4f", 102, pcp4f,     32'h0);
        chk("wrap_addr",  102, imem_addr, 32'h0);
        chk("wrap_pcf2",  102, pcf,       32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
